// File: rtl/memory_interface_pkg.sv
// Shared definitions for the memory-side stage: default bus widths, the
// transaction FSM state encoding and the operation encoding.
// Imported by the memory interface top, its bus interface and the bench.
package cpu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_t;

endpackage

// File: rtl/memory_interface_if.sv
// Bus bundle between the control unit / datapath and the memory stage.
// master: drives BusMuxOut, MARin, MDRin, Read, Write; observes status.
// slave : memory stage; drives MAR_q, MDR_q, mem_busy, mem_done, cmd_err.
interface memory_interface_if
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] BusMuxOut;
  logic                  MARin;
  logic                  MDRin;
  logic                  Read;
  logic                  Write;
  logic [ADDR_WIDTH-1:0] MAR_q;
  logic [DATA_WIDTH-1:0] MDR_q;
  logic                  mem_busy;
  logic                  mem_done;
  logic                  cmd_err;

  modport master (
    output BusMuxOut, MARin, MDRin, Read, Write,
    input  MAR_q, MDR_q, mem_busy, mem_done, cmd_err
  );

  modport slave (
    input  BusMuxOut, MARin, MDRin, Read, Write,
    output MAR_q, MDR_q, mem_busy, mem_done, cmd_err
  );

endinterface

// File: rtl/memory_interface_ram_sync.sv
// Single-port word-addressed synchronous RAM, registered read data.
// Ports: clock; we/wdata write at the edge; re loads rdata from addr at the edge.
// Contents are never reset; INIT_FILE is accepted for interface compatibility.
module ram_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_interface.sv
// Memory stage: owns MAR, MDR and main RAM; sequences reads/writes with
// WAIT_STATES extra cycles. Ports: clock, clear (sync, active-high), bus
// (slave modport: BusMuxOut/MARin/MDRin/Read/Write in; MAR_q/MDR_q/status out).
module memory_interface
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic             clock,
  input  logic             clear,
  memory_interface_if.slave bus
);

  localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t                state, next_state;
  op_t                   op, next_op;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] mar, lat_addr;
  logic [DATA_WIDTH-1:0] mdr, lat_data;
  logic                  mem_busy, mem_done, cmd_err;

  logic                  accept, busy_cmd;
  logic                  ram_we, ram_re;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // DONE behaves like IDLE for new commands so transactions can run back-to-back.
  assign accept   = (state == IDLE || state == DONE) && (bus.Read || bus.Write);
  assign busy_cmd = (state == WAIT || state == ACCESS) && (bus.Read || bus.Write);

  // State register and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      op       <= RD;
      wait_cnt <= '0;
      mar      <= '0;
      mdr      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      mem_busy <= 1'b0;
      mem_done <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      state    <= next_state;
      mem_busy <= (next_state == WAIT) || (next_state == ACCESS);
      mem_done <= (next_state == DONE);
      wait_cnt <= (state == WAIT && next_state == WAIT) ? wait_cnt + 4'd1 : 4'd0;

      if (bus.MARin) mar <= bus.BusMuxOut[ADDR_WIDTH-1:0];

      if (accept) begin
        lat_addr <= mar;
        op       <= next_op;
        if (bus.Write) lat_data <= bus.MDRin ? bus.BusMuxOut : mdr;
      end

      if ((accept && bus.Read && bus.Write) || busy_cmd) cmd_err <= 1'b1;

      // A completing read overrides any bus load of MDR in the same cycle.
      if (state == ACCESS && op == RD) mdr <= ram_rdata;
      else if (bus.MDRin)              mdr <= bus.BusMuxOut;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (accept) next_state = (WAIT_STATES > 0) ? WAIT : ACCESS;
        else        next_state = IDLE;
      end
      WAIT:    if (wait_cnt == WAIT_LAST) next_state = ACCESS;
      ACCESS:  next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // RAM control. The RAM read is registered, so it is issued on the edge that
  // enters ACCESS; its data is then ready for MDR at the end of ACCESS.
  always_comb begin
    next_op  = op;
    if (accept) next_op = bus.Write ? WR : RD;
    ram_re   = !clear && (next_state == ACCESS) && (next_op == RD);
    ram_we   = !clear && (state == ACCESS) && (op == WR);
    ram_addr = accept ? mar : lat_addr;
  end

  ram_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (lat_data),
    .rdata (ram_rdata)
  );

  assign bus.MAR_q    = mar;
  assign bus.MDR_q    = mdr;
  assign bus.mem_busy = mem_busy;
  assign bus.mem_done = mem_done;
  assign bus.cmd_err  = cmd_err;

endmodule
